axi_master_bridge: RTL and testbench

//  AXI4 master: converts single-outstanding CPU/cache requests (refill reads, writebacks) into INCR bursts.

---
 rtl/axi_pkg.sv | 30 +++
 rtl/axi_master_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, FSM states and latched-request layout for axi_master_bridge.
// Pure declarations: no latency, no backpressure.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [7:0]  wstrb;
  } req_t;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_master_bridge.sv
// Single-outstanding CPU request -> AXI4 INCR burst master; AXI_MASTER_RESP_CHECK_EN adds sticky err.
// Latency: 1 cycle accept + 1 cycle AR/AW (min) + one cycle per data beat; done is combinational on the last handshake.
// Backpressure: cpu_rready/cpu_wvalid pass straight through to rready/wvalid; req_ready only in IDLE.
module axi_master_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] TXN_ID    = 4'd0,
  parameter int         MAX_BEATS = 8
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_wstrb,

  input  logic [63:0] cpu_wdata,
  input  logic        cpu_wvalid,
  output logic        cpu_wready,
  output logic [63:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_rlast,
  input  logic        cpu_rready,
  output logic        done,
  output logic        err,

  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic [3:0]  awid,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_BEATS - 1);

  state_t     state, state_nxt;
  req_t       req_q;
  logic [7:0] beat_cnt;
  logic       r_hs, w_hs, b_hs, last_beat;

  assign last_beat = (beat_cnt == req_q.len);
  assign r_hs      = (state == ST_R) && rvalid && cpu_rready;
  assign w_hs      = (state == ST_W) && cpu_wvalid && wready;
  assign b_hs      = (state == ST_B) && bvalid;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        req_q.addr  <= req_addr;
        req_q.len   <= clamp_len(req_len, MAX_LEN);
        req_q.size  <= req_size;
        req_q.wstrb <= req_wstrb;
        beat_cnt    <= '0;
      end else if ((r_hs || w_hs) && beat_cnt != 8'hFF) begin
        // Saturate so a slave that never sends rlast cannot wrap the count.
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    awvalid    = 1'b0;
    rready     = 1'b0;
    cpu_rvalid = 1'b0;
    wvalid     = 1'b0;
    cpu_wready = 1'b0;
    bready     = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = aresetn;
        if (req_valid) state_nxt = req_we ? ST_AW : ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = ST_R;
      end
      ST_R: begin
        rready     = cpu_rready;
        cpu_rvalid = rvalid;
        if (r_hs && rlast) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = ST_W;
      end
      ST_W: begin
        wvalid     = cpu_wvalid;
        cpu_wready = wready;
        if (w_hs && last_beat) state_nxt = ST_B;
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign araddr  = req_q.addr;
  assign arid    = TXN_ID;
  assign arlen   = req_q.len;
  assign arsize  = req_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awaddr  = req_q.addr;
  assign awid    = TXN_ID;
  assign awlen   = req_q.len;
  assign awsize  = req_q.size;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid   = TXN_ID;
  assign wdata = cpu_wdata;
  assign wstrb = req_q.wstrb;
  assign wlast = (state == ST_W) && last_beat;

  assign cpu_rdata = rdata;
  assign cpu_rlast = rlast && cpu_rvalid;

`ifdef AXI_MASTER_RESP_CHECK_EN
  logic        err_q;
  logic [31:0] cyc_cnt;
  logic        r_err, b_err;

  // An rlast that disagrees with the beat count is flagged even though the burst still ends on rlast.
  assign r_err = r_hs && ((rresp != AXI_RESP_OKAY) || (rid != TXN_ID) || (rlast != last_beat));
  assign b_err = b_hs && ((bresp != AXI_RESP_OKAY) || (bid != TXN_ID));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q   <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (r_err || b_err) begin
        err_q <= 1'b1;
        $display("axi_master_bridge: response error at cycle %0d addr 0x%08h", cyc_cnt, req_q.addr);
      end
    end
  end

  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp, b_hs};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: read, refill with stall, writeback, clamp, mid-burst reset, bresp error.
module tb_axi_master_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [7:0]  req_wstrb;
  logic [63:0] cpu_wdata;
  logic        cpu_wvalid, cpu_wready;
  logic [63:0] cpu_rdata;
  logic        cpu_rvalid, cpu_rlast, cpu_rready;
  logic        done, err;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache;
  logic        arvalid, arready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

  int n_chk  = 0;
  int n_fail = 0;

  axi_master_bridge #(.TXN_ID(4'd0), .MAX_BEATS(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_wstrb(req_wstrb),
    .cpu_wdata(cpu_wdata), .cpu_wvalid(cpu_wvalid), .cpu_wready(cpu_wready),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rlast(cpu_rlast), .cpu_rready(cpu_rready),
    .done(done), .err(err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_req(input logic we, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [7:0] st);
    req_we    = we;
    req_addr  = a;
    req_len   = l;
    req_size  = s;
    req_wstrb = st;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  logic err_exp;

  initial begin
`ifdef AXI_MASTER_RESP_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    aresetn = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0; req_size = '0; req_wstrb = '0;
    cpu_wdata = '0; cpu_wvalid = 0; cpu_rready = 0;
    arready = 0; awready = 0; wready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    bid = '0; bresp = '0; bvalid = 0;

    repeat (3) step();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outputs", {arvalid, awvalid, wvalid, rready, bready, cpu_rvalid, cpu_wready, done, err}, 0);
    aresetn = 1'b1;
    step();
    chk("idle_req_ready", req_ready, 1);

    // Single-beat read
    send_req(0, 32'h8000_0000, 8'd0, 3'd3, 8'h00);
    #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_ar_fields", {araddr, arid, arlen, arsize, arburst}, {32'h8000_0000, 4'd0, 8'd0, 3'd3, 2'b01});
    chk("t1_ar_attr", {arlock, arcache, arprot}, 0);
    chk("t1_req_ready_busy", req_ready, 0);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = 64'h1122_3344_5566_7788; rlast = 1; cpu_rready = 1;
    #1;
    chk("t1_arvalid_drop", arvalid, 0);
    chk("t1_rbeat", {cpu_rvalid, cpu_rlast, rready, done}, 4'b1111);
    chk("t1_rdata", cpu_rdata, 64'h1122_3344_5566_7788);
    step();
    rvalid = 0; rlast = 0;
    #1;
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", req_ready, 1);

    // Refill burst with consumer stall and a slow arready
    send_req(0, 32'h8000_1000, 8'd3, 3'd3, 8'h00);
    #1;
    chk("t2_ar", {araddr, arlen, arsize}, {32'h8000_1000, 8'd3, 3'd3});
    step();
    chk("t2_ar_hold", arvalid, 1);
    arready = 1;
    step();
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 64'hA000 + 64'(i); rlast = (i == 3);
      if (i == 1) begin
        cpu_rready = 0;
        for (int k = 0; k < 2; k++) begin
          #1;
          chk("t2_stall", {rready, cpu_rvalid, done}, 3'b010);
          step();
        end
      end
      cpu_rready = 1;
      #1;
      chk("t2_beat", {cpu_rvalid, cpu_rlast, done}, {1'b1, (i == 3), (i == 3)});
      chk("t2_rdata", cpu_rdata, 64'hA000 + 64'(i));
      step();
    end
    rvalid = 0; rlast = 0;
    #1;
    chk("t2_idle", req_ready, 1);

    // Writeback: W must wait for the AW handshake
    cpu_wvalid = 1; wready = 1; cpu_wdata = 64'hDEAD;
    send_req(1, 32'h8000_2000, 8'd3, 3'd3, 8'hFF);
    #1;
    chk("t3_aw", {awvalid, awaddr, awid, awlen, awsize, awburst}, {1'b1, 32'h8000_2000, 4'd0, 8'd3, 3'd3, 2'b01});
    chk("t3_aw_attr", {awlock, awcache, awprot}, 0);
    chk("t3_no_early_w", {wvalid, cpu_wready, arvalid}, 0);
    awready = 1;
    step();
    awready = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_wdata = 64'hB0 + 64'(i);
      #1;
      chk("t3_wbeat", {awvalid, wvalid, cpu_wready, wlast, done, wid}, {1'b0, 1'b1, 1'b1, (i == 3), 1'b0, 4'd0});
      chk("t3_wdata", {wdata, wstrb}, {64'hB0 + 64'(i), 8'hFF});
      step();
    end
    cpu_wvalid = 0; wready = 0;
    #1;
    chk("t3_b_wait", {bready, wvalid, done}, 3'b100);
    bvalid = 1; bresp = 2'b00;
    #1;
    chk("t3_done", done, 1);
    step();
    bvalid = 0;
    #1;
    chk("t3_idle", {done, req_ready, err}, 3'b010);

    // Length clamp
    send_req(0, 32'h8000_3000, 8'd20, 3'd3, 8'h00);
    #1;
    chk("t4_clamp", arlen, 8'd7);
    arready = 1;
    step();
    arready = 0;
    for (int i = 0; i < 8; i++) begin
      rvalid = 1; rlast = (i == 7); cpu_rready = 1; rdata = 64'(i);
      #1;
      if (i == 7) chk("t4_last", {cpu_rlast, done}, 2'b11);
      step();
    end
    rvalid = 0; rlast = 0;
    #1;
    chk("t4_idle", req_ready, 1);

    // Reset in the middle of a read burst
    send_req(0, 32'h8000_4000, 8'd3, 3'd3, 8'h00);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rlast = 0; cpu_rready = 1;
    step();
    aresetn = 0;
    step();
    chk("t5_rst_mid", {arvalid, rready, cpu_rvalid, req_ready}, 0);
    aresetn = 1; rvalid = 0;
    step();
    chk("t5_restart_idle", req_ready, 1);

    // Single-beat write with SLVERR response
    cpu_wvalid = 1; wready = 1; cpu_wdata = 64'hC0FFEE;
    send_req(1, 32'h8000_5000, 8'd0, 3'd2, 8'h0F);
    #1;
    chk("t6_aw", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'h8000_5000, 8'd0, 3'd2});
    awready = 1;
    step();
    awready = 0;
    chk("t6_wbeat", {wvalid, wlast, wstrb}, {1'b1, 1'b1, 8'h0F});
    step();
    cpu_wvalid = 0; wready = 0;
    bvalid = 1; bresp = 2'b10;
    #1;
    chk("t6_done", done, 1);
    step();
    bvalid = 0; bresp = 2'b00;
    chk("t6_err", err, err_exp);
    step();
    chk("t6_err_sticky", err, err_exp);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
